// File: rtl/pp_deinterleaver_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pp_deinterleaver_ctrl
// Purpose  : Receive-side ping-pong block deinterleaver. Incoming hard bits
//            are written into one of two NCBPS-bit banks at permuted
//            addresses; each completed bank is drained in natural order.
// Revision : 1.0 - initial release
// ============================================================================
module pp_deinterleaver_ctrl #(
    parameter int NCBPS = 192,
    parameter int D     = 16
) (
    input  logic clk,
    input  logic resetN,
    input  logic flush,
    input  logic valid_in,
    input  logic data_in,
    output logic ready_out,
    output logic valid_out,
    output logic data_out,
    input  logic ready_in
);

    localparam int              AW      = $clog2(NCBPS);
    localparam logic [AW-1:0]   C_LAST  = AW'(NCBPS - 1);
    localparam logic [AW:0]     C_D     = (AW + 1)'(D);
    localparam logic [AW:0]     C_N     = (AW + 1)'(NCBPS);
    localparam logic [AW:0]     C_NM1   = (AW + 1)'(NCBPS - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ready_out;
    logic              r_valid_out;
    logic              r_wsel;
    logic              r_rsel;
    logic [1:0]        r_full;
    logic [AW-1:0]     r_wcnt;
    logic [AW-1:0]     r_rcnt;
    logic [AW-1:0]     r_waddr;
    logic [NCBPS-1:0]  r_bank [0:1];

    logic              w_flush;
    logic              w_wr;
    logic              w_rd;
    logic              w_wwrap;
    logic              w_rwrap;
    logic [1:0]        w_full_nxt;
    logic              w_wsel_nxt;
    logic              w_rsel_nxt;
    logic [AW:0]       w_wsum;
    logic [AW:0]       w_waddr_wide;
    logic [AW-1:0]     w_waddr_nxt;

    // flush only acts in RUN; it wins over any same-cycle transfer
    assign w_flush = (r_state == S_RUN) && flush;
    assign w_wr    = valid_in && r_ready_out;
    assign w_rd    = r_valid_out && ready_in;
    assign w_wwrap = w_wr && (r_wcnt == C_LAST);
    assign w_rwrap = w_rd && (r_rcnt == C_LAST);

    // Incremental permuted address: step by D, fold back by NCBPS-1 on overflow
    assign w_wsum       = {1'b0, r_waddr} + C_D;
    assign w_waddr_wide = (w_wsum >= C_N) ? (w_wsum - C_NM1) : w_wsum;
    assign w_waddr_nxt  = w_waddr_wide[AW-1:0];

    // Next bank-status: write wrap fills one bank while read wrap frees the other
    always_comb begin
        w_full_nxt = r_full;
        w_wsel_nxt = r_wsel;
        w_rsel_nxt = r_rsel;
        if (w_flush) begin
            w_full_nxt = 2'b00;
            w_wsel_nxt = 1'b0;
            w_rsel_nxt = 1'b0;
        end else begin
            if (w_wwrap) begin
                w_full_nxt[r_wsel] = 1'b1;
                w_wsel_nxt         = ~r_wsel;
            end
            if (w_rwrap) begin
                w_full_nxt[r_rsel] = 1'b0;
                w_rsel_nxt         = ~r_rsel;
            end
        end
    end

    // Control FSM with registered handshake outputs derived from next bank status
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_INIT;
            r_ready_out <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_state     <= S_RUN;
                    r_ready_out <= !w_full_nxt[w_wsel_nxt];
                    r_valid_out <= w_full_nxt[w_rsel_nxt];
                end
                S_RUN: begin
                    if (flush) begin
                        r_state     <= S_FLUSH;
                        r_ready_out <= 1'b0;
                        r_valid_out <= 1'b0;
                    end else begin
                        r_ready_out <= !w_full_nxt[w_wsel_nxt];
                        r_valid_out <= w_full_nxt[w_rsel_nxt];
                    end
                end
                S_FLUSH: begin
                    r_state     <= S_RUN;
                    r_ready_out <= !w_full_nxt[w_wsel_nxt];
                    r_valid_out <= w_full_nxt[w_rsel_nxt];
                end
                default: begin
                    r_state     <= S_INIT;
                    r_ready_out <= 1'b0;
                    r_valid_out <= 1'b0;
                end
            endcase
        end
    end

    // Bank selects, full flags, and write/read counters
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_full  <= 2'b00;
            r_wsel  <= 1'b0;
            r_rsel  <= 1'b0;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_waddr <= '0;
        end else begin
            r_full <= w_full_nxt;
            r_wsel <= w_wsel_nxt;
            r_rsel <= w_rsel_nxt;
            if (w_flush) begin
                r_wcnt  <= '0;
                r_rcnt  <= '0;
                r_waddr <= '0;
            end else begin
                if (w_wr) begin
                    if (w_wwrap) begin
                        r_wcnt  <= '0;
                        r_waddr <= '0;
                    end else begin
                        r_wcnt  <= r_wcnt + 1'b1;
                        r_waddr <= w_waddr_nxt;
                    end
                end
                if (w_rd) begin
                    r_rcnt <= w_rwrap ? '0 : (r_rcnt + 1'b1);
                end
            end
        end
    end

    // Bank storage; contents need no reset
    always_ff @(posedge clk) begin
        if (w_wr && !w_flush) begin
            r_bank[r_wsel][r_waddr] <= data_in;
        end
    end

    assign ready_out = r_ready_out;
    assign valid_out = r_valid_out;
    // Gate with valid so data_out reads 0 whenever no bank is being drained
    assign data_out  = r_valid_out & r_bank[r_rsel][r_rcnt];

endmodule
`default_nettype wire

// File: tb/tb_pp_deinterleaver_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pp_deinterleaver_ctrl
// Purpose  : Directed self-checking bench for pp_deinterleaver_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pp_deinterleaver_ctrl;

    logic clk = 1'b0;
    logic resetN, flush, valid_in, data_in, ready_in;
    logic ready_out, valid_out, data_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit inq[$];
    bit outq[$];

    int in_total, out_total, in192_cyc, first_vld_cyc, out192_cyc, rdy_ret_cyc;
    int gaps, in_stalls, stall_err;
    bit rdy_low, prev_stall, prev_dat, timed_out;
    bit s_rdy, s_vld, s_dat;

    pp_deinterleaver_ctrl #(.NCBPS(192), .D(16)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .flush     (flush),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic reset_metrics();
        in_total = 0; out_total = 0;
        in192_cyc = -1; first_vld_cyc = -1; out192_cyc = -1; rdy_ret_cyc = -1;
        gaps = 0; in_stalls = 0; stall_err = 0;
        rdy_low = 0; prev_stall = 0; prev_dat = 0; timed_out = 0;
        outq.delete();
    endtask

    // One clock: drive inputs after the edge, sample outputs on the falling edge
    task automatic step(input bit vin, input bit din, input bit rin, input bit fl);
        cyc++;
        valid_in = vin; data_in = din; ready_in = rin; flush = fl;
        @(negedge clk);
        s_rdy = ready_out; s_vld = valid_out; s_dat = data_out;
        @(posedge clk);
        #1;
    endtask

    // Streams inq into the DUT and collects outputs into outq
    task automatic run(input int max_cyc, input int pv, input int pr, input int n_out);
        int c = 0;
        bit vin, din, rin;
        while (!(n_out > 0 && outq.size() >= n_out)) begin
            if (c >= max_cyc) begin
                if (n_out > 0) timed_out = 1;
                break;
            end
            vin = (inq.size() > 0) && ($urandom_range(99) < pv);
            din = vin ? inq[0] : 1'($urandom_range(1));
            rin = ($urandom_range(99) < pr);
            step(vin, din, rin, 1'b0);
            if (prev_stall && (!s_vld || s_dat != prev_dat)) stall_err++;
            prev_stall = s_vld && !rin;
            prev_dat   = s_dat;
            if (vin && !s_rdy) in_stalls++;
            if (!s_rdy) rdy_low = 1;
            else if (rdy_low && rdy_ret_cyc < 0) rdy_ret_cyc = cyc;
            if (vin && s_rdy) begin
                void'(inq.pop_front());
                in_total++;
                if (in_total == 192) in192_cyc = cyc;
            end
            if (s_vld) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end else if (first_vld_cyc >= 0) begin
                gaps++;
            end
            if (s_vld && rin) begin
                outq.push_back(s_dat);
                out_total++;
                if (out_total == 192) out192_cyc = cyc;
            end
            c++;
        end
    endtask

    function automatic bit [191:0] rand_blk();
        bit [191:0] r;
        for (int i = 0; i < 192; i++) r[i] = 1'($urandom_range(1));
        return r;
    endfunction

    // Reference transmit interleaver: original bit k goes to position 12*(k%16)+k/16
    task automatic push_interleaved(input bit [191:0] o);
        bit [191:0] t;
        for (int k = 0; k < 192; k++) t[12 * (k % 16) + k / 16] = o[k];
        for (int j = 0; j < 192; j++) inq.push_back(t[j]);
    endtask

    function automatic bit [191:0] out_blk(input int b);
        bit [191:0] r = '0;
        if (outq.size() >= (b + 1) * 192)
            for (int i = 0; i < 192; i++) r[i] = outq[b * 192 + i];
        return r;
    endfunction

    task automatic test_reset();
        resetN = 0; flush = 0; valid_in = 0; data_in = 0; ready_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
        total++; if (data_out !== 1'b0) begin bad++; $display("FAIL rst_data got=%b exp=0", data_out); end
        @(posedge clk); #1;
        resetN = 1;
        @(negedge clk);
        total++; if (ready_out !== 1'b0 || valid_out !== 1'b0) begin
            bad++; $display("FAIL init_cycle ready=%b valid=%b exp=0/0", ready_out, valid_out);
        end
        @(negedge clk);
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL run_ready got=%b exp=1", ready_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_map();
        int js[4] = '{12, 1, 191, 11};
        int ks[4] = '{1, 16, 191, 176};
        bit [191:0] exp_v, got;
        for (int t = 0; t < 4; t++) begin
            reset_metrics();
            for (int j = 0; j < 192; j++) inq.push_back(j == js[t]);
            run(1000, 100, 100, 192);
            exp_v = '0; exp_v[ks[t]] = 1'b1;
            got = out_blk(0);
            total++; if (timed_out || got !== exp_v) begin
                bad++; $display("FAIL addr_map j=%0d got=%h exp=%h", js[t], got, exp_v);
            end
        end
    endtask

    task automatic test_round_trip();
        bit [191:0] o [4];
        reset_metrics();
        for (int b = 0; b < 4; b++) begin o[b] = rand_blk(); push_interleaved(o[b]); end
        run(2000, 100, 100, 768);
        for (int b = 0; b < 4; b++) begin
            total++; if (timed_out || out_blk(b) !== o[b]) begin
                bad++; $display("FAIL round_trip blk=%0d got=%h exp=%h", b, out_blk(b), o[b]);
            end
        end
        total++; if (first_vld_cyc != in192_cyc + 1) begin
            bad++; $display("FAIL latency valid_cyc=%0d exp=%0d", first_vld_cyc, in192_cyc + 1);
        end
        total++; if (gaps != 0 || in_stalls != 0) begin
            bad++; $display("FAIL throughput out_gaps=%0d in_stalls=%0d exp=0/0", gaps, in_stalls);
        end
    endtask

    task automatic test_backpressure();
        bit [191:0] o [3];
        int errs = 0;
        reset_metrics();
        for (int b = 0; b < 3; b++) begin o[b] = rand_blk(); push_interleaved(o[b]); end
        run(400, 100, 0, 0);
        total++; if (in_total != 384) begin bad++; $display("FAIL bp_accepted got=%0d exp=384", in_total); end
        total++; if (s_rdy !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", s_rdy); end
        run(2000, 100, 100, 576);
        total++; if (rdy_ret_cyc != out192_cyc + 1) begin
            bad++; $display("FAIL bp_ready_return cyc=%0d exp=%0d", rdy_ret_cyc, out192_cyc + 1);
        end
        for (int b = 0; b < 3; b++) if (out_blk(b) !== o[b]) errs++;
        total++; if (timed_out || errs != 0 || stall_err != 0) begin
            bad++; $display("FAIL bp_data bad_blocks=%0d stall_err=%0d exp=0/0", errs, stall_err);
        end
    endtask

    task automatic test_random();
        localparam int NB = 40;
        bit [191:0] o [NB];
        int errs = 0;
        reset_metrics();
        for (int b = 0; b < NB; b++) begin o[b] = rand_blk(); push_interleaved(o[b]); end
        run(60000, 70, 60, NB * 192);
        run(50, 100, 100, 0);
        for (int b = 0; b < NB; b++) if (out_blk(b) !== o[b]) errs++;
        total++; if (timed_out || errs != 0) begin
            bad++; $display("FAIL random_data bad_blocks=%0d timeout=%0d exp=0/0", errs, timed_out);
        end
        total++; if (outq.size() != NB * 192 || inq.size() != 0) begin
            bad++; $display("FAIL random_count out=%0d left=%0d exp=%0d/0", outq.size(), inq.size(), NB * 192);
        end
        total++; if (stall_err != 0) begin bad++; $display("FAIL random_stall got=%0d exp=0", stall_err); end
    endtask

    task automatic test_flush();
        bit [191:0] z;
        reset_metrics();
        push_interleaved(rand_blk());
        run(300, 100, 0, 0);
        for (int j = 0; j < 101; j++) inq.push_back(1'($urandom_range(1)));
        run(100, 100, 0, 0);
        step(1'b1, inq[0], 1'b0, 1'b1);
        total++; if (s_vld !== 1'b1 || in_total != 292) begin
            bad++; $display("FAIL flush_setup valid=%b accepted=%0d exp=1/292", s_vld, in_total);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (s_vld !== 1'b0 || s_rdy !== 1'b0) begin
            bad++; $display("FAIL flush_next valid=%b ready=%b exp=0/0", s_vld, s_rdy);
        end
        inq.delete();
        reset_metrics();
        z = rand_blk();
        push_interleaved(z);
        run(1000, 100, 100, 192);
        run(60, 100, 100, 0);
        total++; if (timed_out || outq.size() != 192 || out_blk(0) !== z) begin
            bad++; $display("FAIL flush_new_block n=%0d got=%h exp=%h", outq.size(), out_blk(0), z);
        end
    endtask

    task automatic test_reset_mid();
        bit [191:0] o;
        reset_metrics();
        push_interleaved(rand_blk());
        run(300, 100, 0, 0);
        for (int j = 0; j < 50; j++) inq.push_back(1'($urandom_range(1)));
        run(60, 100, 0, 0);
        total++; if (s_vld !== 1'b1) begin bad++; $display("FAIL mid_setup valid got=%b exp=1", s_vld); end
        resetN = 0;
        #1;
        total++; if (ready_out !== 1'b0 || valid_out !== 1'b0 || data_out !== 1'b0) begin
            bad++; $display("FAIL mid_reset ready=%b valid=%b data=%b exp=0/0/0", ready_out, valid_out, data_out);
        end
        @(posedge clk); #1;
        resetN = 1;
        repeat (2) @(posedge clk);
        #1;
        inq.delete();
        reset_metrics();
        o = rand_blk();
        push_interleaved(o);
        run(1000, 100, 100, 192);
        total++; if (timed_out || out_blk(0) !== o) begin
            bad++; $display("FAIL mid_recover got=%h exp=%h", out_blk(0), o);
        end
    endtask

    initial begin
        test_reset();
        test_addr_map();
        test_round_trip();
        test_backpressure();
        test_random();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
